alu_mdu: RTL and testbench
==========================

// Module: alu_mdu
// PURPOSE
//  Parametrised per-thread ALU with an integrated iterative multiply/divide unit (RV32IM-style).
//  Sits in each thread's execute stage and replaces the fixed-width single-cycle ALU.
//  Uses a valid/ready handshake on input and output, so the core stalls on multi-cycle MUL/DIV.
//  Adds unsigned compares/branches, immediate operand select and an illegal-op flag.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width in bits; must be >= 8 and a power of 2
//  ENABLE_MDU  1   1 = ops 16-23 supported; 0 = ops 16-23 are illegal
// PORTS
//  clk        in   1           clock; all state updates on posedge
//  reset      in   1           synchronous, active-low: 0 at posedge resets the block
//  in_valid   in   1           request valid
//  in_ready   out  1           block accepts the request this cycle
//  op         in   5           operation code (table in BEHAVIOUR)
//  use_imm    in   1           1 = operand B is sext(imm12), else rs2 (ops 0,2-9 only)
//  rs1        in   DATA_WIDTH  operand A
//  rs2        in   DATA_WIDTH  operand B
//  imm12      in   12          immediate, sign-extended to DATA_WIDTH
//  out_valid  out  1           result valid; held until consumed
//  out_ready  in   1           consumer takes the result this cycle
//  result     out  DATA_WIDTH  registered result
//  illegal    out  1           qualifies result: op was illegal, result = 0
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, result=0, illegal=0. In-flight MUL/DIV is aborted and no result is produced.
//  Ops: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND,
//   10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU (result 1/0),
//   16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; 24-31 illegal.
//  Accept: in_valid & in_ready at a posedge. in_ready = (state==IDLE) & (!out_valid | out_ready).
//  Single-cycle ops (0-15, illegal): result/out_valid are registered at the accept edge (latency 1).
//   Back-to-back throughput is 1 op/cycle while out_ready=1.
//  Signedness: SLT/BLT/BGE/SRA/DIV/REM are signed; SLTU/BLTU/BGEU/SRL/DIVU/REMU are unsigned.
//  Shifts use only the low $clog2(DATA_WIDTH) bits of B. ADD/SUB/MUL wrap modulo 2^DATA_WIDTH.
//  use_imm is ignored for SUB and ops >= 10.
//  FSM IDLE -> MUL_ITER | DIV_ITER -> IDLE:
//   - Accepting op 16-23 loads operands (magnitudes for signed forms) and the cycle counter = DATA_WIDTH.
//   - Each iteration does 1 shift-add (MUL) or 1 restoring-subtract step (DIV), counter--.
//   - At counter==0: sign correction, result register and out_valid=1, return to IDLE.
//   - out_valid rises after edge T+DATA_WIDTH+1, where T = accept edge. in_ready=0 during iteration.
//  MULH/MULHSU/MULHU return the upper half of the 2*DATA_WIDTH product.
//   Signs: s*s, s*u, u*u respectively.
//  Divide by zero: DIV/DIVU -> all ones; REM/REMU -> rs1. Takes the full iteration latency.
//  Signed overflow (MIN / -1): DIV -> MIN, REM -> 0.
//  Output hold: while out_valid & !out_ready, result and illegal are stable.
//   A single-cycle op is accepted on the same edge the old result is consumed.
//  Illegal op (24-31, or 16-23 when ENABLE_MDU=0): latency 1, result=0, illegal=1.
//  illegal is cleared with the next accepted result.
//  reset has priority over all inputs, including a simultaneous accept.
// TESTING
//  ADD rs1=7 rs2=0xFFFFFFFF, out_ready=1 -> next cycle result=6, out_valid=1.
//  ADDI use_imm=1 imm12=0xFFF rs1=5 -> 4. SLTU 1 vs 0xFFFFFFFF -> 1. SLT -> 0.
//  MULH rs1=0x80000000 rs2=2 -> 0xFFFFFFFF after 33 cycles; in_ready=0 throughout.
//  MUL 6*7 -> 42.
//  DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. DIVU 9/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
//  Hold out_ready=0 for 5 cycles after ADD -> result stable and in_ready=0.
//   Then release out_ready with a new op pending -> both transfer on one edge.
//  Start DIV, pull reset low at iteration 10 -> out_valid stays 0, in_ready=1 after release.
//  op=25 -> illegal=1, result=0.

Source files
------------

// File: rtl/alu_mdu.sv
// Per-thread execute-stage ALU with an iterative multiply/divide unit behind a
// valid/ready handshake. Single-cycle ops complete in one cycle, MUL/DIV in DATA_WIDTH+1.
module alu_mdu #(
  parameter int DATA_WIDTH = 32,
  parameter bit ENABLE_MDU = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            op,
  input  logic                  use_imm,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic [11:0]           imm12,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(W);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, MUL_ITER, DIV_ITER} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic [2:0]      mdu_op;
  logic [W-1:0]    mdu_m;
  logic [2*W-1:0]  prod;
  logic            q_neg, r_neg;

  logic [W-1:0]    imm_ext, operand_b, alu_res, mdu_res;
  logic [SW-1:0]   shamt;
  logic            use_b_imm, is_mdu, op_illegal, accept, start_mdu, iter_done;
  logic            sign_a, sign_b, a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      mul_sum, div_shift;
  logic [W+1:0]    div_diff;
  logic [2*W-1:0]  prod_signed;
  logic [W-1:0]    quot, rem;

  assign imm_ext    = W'($signed(imm12));
  assign use_b_imm  = use_imm && (op <= 5'd9) && (op != 5'd1);
  assign operand_b  = use_b_imm ? imm_ext : rs2;
  assign shamt      = operand_b[SW-1:0];
  assign is_mdu     = (op[4:3] == 2'b10);
  assign op_illegal = (op[4:3] == 2'b11) || (is_mdu && !ENABLE_MDU);
  assign accept     = in_valid && in_ready;
  assign start_mdu  = accept && is_mdu && ENABLE_MDU;

  // Single-cycle ALU and branch-compare results
  always_comb begin
    alu_res = '0;
    case (op)
      5'd0:    alu_res = rs1 + operand_b;
      5'd1:    alu_res = rs1 - rs2;
      5'd2:    alu_res = rs1 << shamt;
      5'd3:    alu_res[0] = ($signed(rs1) < $signed(operand_b));
      5'd4:    alu_res[0] = (rs1 < operand_b);
      5'd5:    alu_res = rs1 ^ operand_b;
      5'd6:    alu_res = rs1 >> shamt;
      5'd7:    alu_res = $signed(rs1) >>> shamt;
      5'd8:    alu_res = rs1 | operand_b;
      5'd9:    alu_res = rs1 & operand_b;
      5'd10:   alu_res[0] = (rs1 == rs2);
      5'd11:   alu_res[0] = (rs1 != rs2);
      5'd12:   alu_res[0] = ($signed(rs1) < $signed(rs2));
      5'd13:   alu_res[0] = ($signed(rs1) >= $signed(rs2));
      5'd14:   alu_res[0] = (rs1 < rs2);
      5'd15:   alu_res[0] = (rs1 >= rs2);
      default: alu_res = '0;
    endcase
  end

  // Operand signedness: op[2] selects the divide group, op[1:0] the variant
  assign sign_a = op[2] ? !op[0] : (op[1:0] != 2'b11);
  assign sign_b = op[2] ? !op[0] : !op[1];
  assign a_neg  = sign_a && rs1[W-1];
  assign b_neg  = sign_b && rs2[W-1];
  assign a_mag  = a_neg ? -rs1 : rs1;
  assign b_mag  = b_neg ? -rs2 : rs2;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_mdu) state_next = op[2] ? DIV_ITER : MUL_ITER;
      MUL_ITER: if (count == '0) state_next = IDLE;
      DIV_ITER: if (count == '0) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state == IDLE) && (!out_valid || out_ready);
    iter_done = (state != IDLE) && (count == '0);
  end

  // prod holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV
  assign mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mdu_m} : {(W+1){1'b0}});
  assign div_shift = prod[2*W-1:W-1];
  assign div_diff  = {1'b0, div_shift} - {2'b00, mdu_m};

  always_ff @(posedge clk) begin
    if (start_mdu) begin
      mdu_op <= op[2:0];
      count  <= CW'(W);
      mdu_m  <= op[2] ? b_mag : a_mag;
      prod   <= {{W{1'b0}}, (op[2] ? a_mag : b_mag)};
      q_neg  <= op[2] ? ((a_neg ^ b_neg) && (rs2 != '0)) : (a_neg ^ b_neg);
      r_neg  <= a_neg;
    end else if (state == MUL_ITER && count != '0) begin
      prod  <= {mul_sum, prod[W-1:1]};
      count <= count - CW'(1);
    end else if (state == DIV_ITER && count != '0) begin
      if (!div_diff[W+1]) prod <= {div_diff[W-1:0], prod[W-2:0], 1'b1};
      else                prod <= {prod[2*W-2:0], 1'b0};
      count <= count - CW'(1);
    end
  end

  // Sign correction; a zero divisor leaves quotient all ones and remainder = dividend
  assign prod_signed = q_neg ? -prod : prod;
  assign quot        = prod[W-1:0];
  assign rem         = prod[2*W-1:W];

  always_comb begin
    mdu_res = '0;
    case (mdu_op)
      3'b000:                 mdu_res = prod_signed[W-1:0];
      3'b001, 3'b010, 3'b011: mdu_res = prod_signed[2*W-1:W];
      3'b100, 3'b101:         mdu_res = q_neg ? -quot : quot;
      default:                mdu_res = r_neg ? -rem : rem;
    endcase
  end

  // Output register: a new result may load on the same edge the old one is consumed
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
    end else if (accept && !start_mdu) begin
      out_valid <= 1'b1;
      result    <= op_illegal ? '0 : alu_res;
      illegal   <= op_illegal;
    end else if (iter_done) begin
      out_valid <= 1'b1;
      result    <= mdu_res;
      illegal   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expected results are queued when a request is driven
// and popped when the matching output appears.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = '0;
  logic        use_imm = 1'b0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [11:0] imm12 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        illegal;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
  } exp_t;
  exp_t exp_q[$];

  alu_mdu #(.DATA_WIDTH(32), .ENABLE_MDU(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .use_imm(use_imm), .rs1(rs1), .rs2(rs2), .imm12(imm12),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Independent reference model using wide native arithmetic
  function automatic logic [31:0] ref_model(input logic [4:0] o, input logic ui,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [11:0] im);
    logic [31:0] bb;
    longint sa, sb, sp;
    longint unsigned ua, ub, up;
    bb = (ui && o <= 5'd9 && o != 5'd1) ? {{20{im[11]}}, im} : b;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      5'd0:  return a + bb;
      5'd1:  return a - b;
      5'd2:  return a << bb[4:0];
      5'd3:  return {31'b0, $signed(a) < $signed(bb)};
      5'd4:  return {31'b0, a < bb};
      5'd5:  return a ^ bb;
      5'd6:  return a >> bb[4:0];
      5'd7:  return $signed(a) >>> bb[4:0];
      5'd8:  return a | bb;
      5'd9:  return a & bb;
      5'd10: return {31'b0, a == b};
      5'd11: return {31'b0, a != b};
      5'd12: return {31'b0, $signed(a) < $signed(b)};
      5'd13: return {31'b0, $signed(a) >= $signed(b)};
      5'd14: return {31'b0, a < b};
      5'd15: return {31'b0, a >= b};
      5'd16: begin sp = sa * sb; return sp[31:0]; end
      5'd17: begin sp = sa * sb; return sp[63:32]; end
      5'd18: begin sp = sa * longint'(ub); return sp[63:32]; end
      5'd19: begin up = ua * ub; return up[63:32]; end
      5'd20: begin if (b == 0) return 32'hFFFF_FFFF; sp = sa / sb; return sp[31:0]; end
      5'd21: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      5'd22: begin if (b == 0) return a; sp = sa % sb; return sp[31:0]; end
      5'd23: begin if (b == 0) return a; return a % b; end
      default: return 32'h0;
    endcase
  endfunction

  // Drive one request and hold it until accepted; starts and ends 1ns after a posedge
  task automatic applyStimulus(input logic [4:0] o, input logic ui, input logic [31:0] a,
                               input logic [31:0] b, input logic [11:0] im);
    int waited = 0;
    op = o; use_imm = ui; rs1 = a; rs2 = b; imm12 = im; in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("[TB] FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic getResult(output logic [31:0] r, output logic il, output bit got);
    got = 1'b0; r = '0; il = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        r = result; il = illegal; got = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; op = 5'd0; rs1 = 32'd1; rs2 = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++; if (result !== 32'h0) begin fails++; $display("[TB] FAIL reset_result: got %h required 0", result); end
    checks++; if (illegal !== 1'b0) begin fails++; $display("[TB] FAIL reset_illegal: got %0b required 0", illegal); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready); end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_vectors();
    logic [4:0]  vop [12] = '{5'd0, 5'd0, 5'd4, 5'd3, 5'd1, 5'd7, 5'd6, 5'd2, 5'd15, 5'd12, 5'd10, 5'd11};
    logic        vui [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] va  [12] = '{32'd7, 32'd5, 32'd1, 32'd1, 32'd10, 32'h8000_0000, 32'h8000_0000,
                              32'd1, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'd5};
    logic [31:0] vb  [12] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'h24,
                              32'h24, 32'd0, 32'd2, 32'd0, 32'd5, 32'd5};
    logic [11:0] vim [12] = '{12'h0, 12'hFFF, 12'h0, 12'h0, 12'hFFF, 12'h0, 12'h0, 12'h03F,
                              12'h0, 12'h0, 12'h0, 12'h0};
    logic [31:0] vex [12] = '{32'd6, 32'd4, 32'd1, 32'd0, 32'd7, 32'hF800_0000, 32'h0800_0000,
                              32'h8000_0000, 32'd0, 32'd1, 32'd1, 32'd0};
    logic [31:0] r; logic il; bit got; exp_t e;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back('{res: vex[i], ill: 1'b0});
      applyStimulus(vop[i], vui[i], va[i], vb[i], vim[i]);
      getResult(r, il, got);
      e = exp_q.pop_front();
      checks++;
      if (!got || r !== e.res || il !== e.ill) begin
        fails++;
        $display("[TB] FAIL alu_vec%0d: got %h/ill=%0b (valid=%0b) required %h/ill=%0b", i, r, il, got, e.res, e.ill);
      end
    end
  endtask

  task automatic test_mdu_vectors();
    logic [4:0]  vop [12] = '{5'd16, 5'd17, 5'd20, 5'd22, 5'd21, 5'd23, 5'd19, 5'd18, 5'd20, 5'd22, 5'd20, 5'd22};
    logic [31:0] va  [12] = '{32'd6, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'hFFFF_FFFB, 32'hFFFF_FFFB};
    logic [31:0] vb  [12] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0, 32'd0};
    logic [31:0] vex [12] = '{32'd42, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd9,
                              32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'hFFFF_FFFB};
    logic [31:0] r; logic il; bit got; exp_t e;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back('{res: vex[i], ill: 1'b0});
      applyStimulus(vop[i], 1'b0, va[i], vb[i], 12'h0);
      getResult(r, il, got);
      e = exp_q.pop_front();
      checks++;
      if (!got || r !== e.res || il !== e.ill) begin
        fails++;
        $display("[TB] FAIL mdu_vec%0d: got %h/ill=%0b (valid=%0b) required %h/ill=%0b", i, r, il, got, e.res, e.ill);
      end
    end
  endtask

  task automatic test_mul_latency();
    int cycles = 0;
    bit ready_seen = 1'b0;
    exp_t e;
    exp_q.push_back('{res: 32'hFFFF_FFFF, ill: 1'b0});
    applyStimulus(5'd17, 1'b0, 32'h8000_0000, 32'd2, 12'h0);
    while (!out_valid && cycles < 100) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    checks++; if (cycles != 33) begin fails++; $display("[TB] FAIL mulh_latency: got %0d cycles required 33", cycles); end
    checks++; if (ready_seen) begin fails++; $display("[TB] FAIL mulh_in_ready: got in_ready=1 during iteration required 0"); end
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || result !== e.res) begin
      fails++; $display("[TB] FAIL mulh_result: got %h (valid=%0b) required %h", result, out_valid, e.res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [4:0] o; logic ui; logic [31:0] a, b; logic [11:0] im;
    logic [31:0] r; logic il; bit got; exp_t e;
    for (int i = 0; i < 30; i++) begin
      o = 5'($urandom_range(0, 23));
      ui = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      im = 12'($urandom);
      exp_q.push_back('{res: ref_model(o, ui, a, b, im), ill: 1'b0});
      applyStimulus(o, ui, a, b, im);
      getResult(r, il, got);
      e = exp_q.pop_front();
      checks++;
      if (!got || r !== e.res || il !== e.ill) begin
        fails++;
        $display("[TB] FAIL random%0d op=%0d a=%h b=%h: got %h/ill=%0b required %h", i, o, a, b, r, il, e.res);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  bop [5] = '{5'd0, 5'd1, 5'd5, 5'd8, 5'd9};
    logic [31:0] ba  [5] = '{32'd100, 32'd100, 32'hF0F0, 32'h0F00, 32'hFFFF};
    logic [31:0] bb  [5] = '{32'd23, 32'd23, 32'h00FF, 32'h00F0, 32'h1234};
    logic [31:0] bex [5] = '{32'd123, 32'd77, 32'hF00F, 32'h0FF0, 32'h1234};
    exp_t e;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || result !== e.res || illegal !== e.ill) begin
          fails++; $display("[TB] FAIL b2b%0d: got %h (valid=%0b) required %h", i - 1, result, out_valid, e.res);
        end
      end
      if (i < 5) begin
        op = bop[i]; use_imm = 1'b0; rs1 = ba[i]; rs2 = bb[i]; in_valid = 1'b1;
        exp_q.push_back('{res: bex[i], ill: 1'b0});
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ready%0d: got %0b required 1", i, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    bit bad = 1'b0;
    exp_t e;
    out_ready = 1'b0;
    exp_q.push_back('{res: 32'd7, ill: 1'b0});
    applyStimulus(5'd0, 1'b0, 32'd3, 32'd4, 12'h0);
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || result !== e.res || in_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad || result !== e.res) begin
      fails++; $display("[TB] FAIL hold_stable: got %h (valid=%0b ready=%0b) required %h held, ready 0", result, out_valid, in_ready, e.res);
    end
    op = 5'd5; rs1 = 32'hF0; rs2 = 32'hFF; use_imm = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back('{res: 32'h0F, ill: 1'b0});
    #1;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL hold_release_ready: got %0b required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || result !== e.res) begin
      fails++; $display("[TB] FAIL hold_same_edge: got %h (valid=%0b) required %h", result, out_valid, e.res);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_div();
    bit seen = 1'b0;
    applyStimulus(5'd20, 1'b0, 32'd100, 32'd7, 12'h0);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_out_valid: got %0b required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL abort_in_ready: got %0b required 1", in_ready); end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen) begin fails++; $display("[TB] FAIL abort_no_result: got out_valid=1 after abort required 0"); end
  endtask

  task automatic test_illegal();
    logic [4:0] iop [3] = '{5'd25, 5'd31, 5'd0};
    logic [31:0] r; logic il; bit got; exp_t e;
    exp_q.push_back('{res: 32'd0, ill: 1'b1});
    exp_q.push_back('{res: 32'd0, ill: 1'b1});
    exp_q.push_back('{res: 32'd3, ill: 1'b0});
    for (int i = 0; i < 3; i++) begin
      applyStimulus(iop[i], 1'b0, 32'd1, 32'd2, 12'h0);
      getResult(r, il, got);
      e = exp_q.pop_front();
      checks++;
      if (!got || r !== e.res || il !== e.ill) begin
        fails++; $display("[TB] FAIL illegal%0d: got %h/ill=%0b required %h/ill=%0b", i, r, il, e.res, e.ill);
      end
    end
  endtask

  initial begin
    $display("[TB] starting alu_mdu bench");
    test_reset();
    test_alu_vectors();
    test_mdu_vectors();
    test_mul_latency();
    test_back_to_back();
    test_hold();
    test_reset_mid_div();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
